// File: rtl/ex_mem_pkg.sv
// Shared definitions for the EX/MEM stage: opcode constants, ALU operation
// encoding and the zero-register index.
package ex_mem_pkg;

    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [10:0] OPC_CBZ  = 11'b10110100000;

    localparam logic [4:0] XZR_IDX = 5'd31;

    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_ORR   = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_SUB   = 4'b0110,
        ALU_PASSB = 4'b0111
    } alu_op_e;

    // Map an R-type opcode onto an ALU operation; unknown opcodes fall back to add.
    function automatic alu_op_e decode_rtype(input logic [10:0] opc);
        alu_op_e op;
        case (opc)
            OPC_ADD: op = ALU_ADD;
            OPC_SUB: op = ALU_SUB;
            OPC_AND: op = ALU_AND;
            OPC_ORR: op = ALU_ORR;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ex_mem_if.sv
// Bundle of EX-stage inputs, writeback forwarding source and MEM-stage outputs.
interface ex_mem_if;

    logic        EX_MEM_Flush;
    logic        ALUSrc_E, MemToReg_E, RegWrite_E, MemRead_E, MemWrite_E, Branch_E;
    logic [1:0]  ALUOp_E;
    logic [63:0] ReadData1_E, ReadData2_E, signExtendedData_E;
    logic [10:0] opcode_E;
    logic [4:0]  DestinationReg_E, Rs1_E, Rs2_E;
    logic [9:0]  current_pc_E;
    logic [63:0] Result_W;
    logic        RegWrite_W;
    logic [4:0]  DestinationReg_W;
    logic        RegWrite_M, MemToReg_M, MemRead_M, MemWrite_M;
    logic [63:0] ALUResult_M, WriteData_M;
    logic [4:0]  DestinationReg_M;
    logic        PCSrc_E;
    logic [9:0]  BranchTarget_E;

    modport master (
        output EX_MEM_Flush, ALUSrc_E, MemToReg_E, RegWrite_E, MemRead_E, MemWrite_E,
               Branch_E, ALUOp_E, ReadData1_E, ReadData2_E, signExtendedData_E, opcode_E,
               DestinationReg_E, Rs1_E, Rs2_E, current_pc_E, Result_W, RegWrite_W,
               DestinationReg_W,
        input  RegWrite_M, MemToReg_M, MemRead_M, MemWrite_M, ALUResult_M, WriteData_M,
               DestinationReg_M, PCSrc_E, BranchTarget_E
    );

    modport slave (
        input  EX_MEM_Flush, ALUSrc_E, MemToReg_E, RegWrite_E, MemRead_E, MemWrite_E,
               Branch_E, ALUOp_E, ReadData1_E, ReadData2_E, signExtendedData_E, opcode_E,
               DestinationReg_E, Rs1_E, Rs2_E, current_pc_E, Result_W, RegWrite_W,
               DestinationReg_W,
        output RegWrite_M, MemToReg_M, MemRead_M, MemWrite_M, ALUResult_M, WriteData_M,
               DestinationReg_M, PCSrc_E, BranchTarget_E
    );

endinterface

// File: rtl/ex_mem_alu64.sv
// 64-bit combinational ALU with wrap-around arithmetic and a zero flag.
module alu64
    import ex_mem_pkg::*;
(
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    input  alu_op_e     op_i,
    output logic [63:0] result_o,
    output logic        zero_o
);

    // Operation select
    always_comb begin
        case (op_i)
            ALU_AND:   result_o = a_i & b_i;
            ALU_ORR:   result_o = a_i | b_i;
            ALU_ADD:   result_o = a_i + b_i;
            ALU_SUB:   result_o = a_i - b_i;
            ALU_PASSB: result_o = b_i;
            default:   result_o = a_i + b_i;
        endcase
    end

    assign zero_o = (result_o == 64'd0);

endmodule

// File: rtl/ex_mem.sv
// EX stage with operand forwarding, branch resolution and the EX/MEM pipeline register.
module ex_mem
    import ex_mem_pkg::*;
(
    input logic   clk,
    input logic   reset,
    ex_mem_if.slave bus
);

    logic        rw_q, mtr_q, mr_q, mw_q;
    logic        rw_d, mtr_d, mr_d, mw_d;
    logic [63:0] alu_q, wd_q, alu_d, wd_d;
    logic [4:0]  dst_q, dst_d;

    logic [4:0]  src_b;
    logic [63:0] fwd_a, fwd_b, opnd_b, alu_res;
    logic        alu_zero;
    alu_op_e     alu_op;

    // M beats W; the zero register is never a forwarding target.
    function automatic logic [63:0] fwd_sel(
        input logic [4:0]  src,
        input logic [63:0] raw,
        input logic        m_hit_en,
        input logic [4:0]  m_dst,
        input logic [63:0] m_val,
        input logic        w_en,
        input logic [4:0]  w_dst,
        input logic [63:0] w_val
    );
        logic [63:0] v;
        if (m_hit_en && (m_dst == src) && (src != XZR_IDX)) begin
            v = m_val;
        end else if (w_en && (w_dst == src) && (src != XZR_IDX)) begin
            v = w_val;
        end else begin
            v = raw;
        end
        return v;
    endfunction

    // Operand selection with forwarding
    always_comb begin
        src_b  = (bus.MemWrite_E || bus.Branch_E) ? bus.DestinationReg_E : bus.Rs2_E;
        fwd_a  = fwd_sel(bus.Rs1_E, bus.ReadData1_E, rw_q && !mtr_q, dst_q, alu_q,
                         bus.RegWrite_W, bus.DestinationReg_W, bus.Result_W);
        fwd_b  = fwd_sel(src_b, bus.ReadData2_E, rw_q && !mtr_q, dst_q, alu_q,
                         bus.RegWrite_W, bus.DestinationReg_W, bus.Result_W);
        opnd_b = bus.ALUSrc_E ? bus.signExtendedData_E : fwd_b;
    end

    // ALU control
    always_comb begin
        case (bus.ALUOp_E)
            2'b00:   alu_op = ALU_ADD;
            2'b01:   alu_op = ALU_PASSB;
            2'b10:   alu_op = decode_rtype(bus.opcode_E);
            default: alu_op = ALU_ADD;
        endcase
    end

    alu64 u_alu (
        .a_i      (fwd_a),
        .b_i      (opnd_b),
        .op_i     (alu_op),
        .result_o (alu_res),
        .zero_o   (alu_zero)
    );

    assign bus.PCSrc_E        = bus.Branch_E & alu_zero;
    assign bus.BranchTarget_E = bus.current_pc_E + {bus.signExtendedData_E[7:0], 2'b00};

    // Next-state: a flush squashes controls but leaves the data fields untouched
    always_comb begin
        if (bus.EX_MEM_Flush) begin
            rw_d  = 1'b0;
            mtr_d = 1'b0;
            mr_d  = 1'b0;
            mw_d  = 1'b0;
            alu_d = alu_q;
            wd_d  = wd_q;
            dst_d = dst_q;
        end else begin
            rw_d  = bus.RegWrite_E;
            mtr_d = bus.MemToReg_E;
            mr_d  = bus.MemRead_E;
            mw_d  = bus.MemWrite_E;
            alu_d = alu_res;
            wd_d  = fwd_b;
            dst_d = bus.DestinationReg_E;
        end
    end

    // EX/MEM pipeline register
    always_ff @(posedge clk) begin
        if (reset) begin
            rw_q  <= 1'b0;
            mtr_q <= 1'b0;
            mr_q  <= 1'b0;
            mw_q  <= 1'b0;
            alu_q <= 64'd0;
            wd_q  <= 64'd0;
            dst_q <= 5'd0;
        end else begin
            rw_q  <= rw_d;
            mtr_q <= mtr_d;
            mr_q  <= mr_d;
            mw_q  <= mw_d;
            alu_q <= alu_d;
            wd_q  <= wd_d;
            dst_q <= dst_d;
        end
    end

    assign bus.RegWrite_M       = rw_q;
    assign bus.MemToReg_M       = mtr_q;
    assign bus.MemRead_M        = mr_q;
    assign bus.MemWrite_M       = mw_q;
    assign bus.ALUResult_M      = alu_q;
    assign bus.WriteData_M      = wd_q;
    assign bus.DestinationReg_M = dst_q;

endmodule

// File: tb/tb_ex_mem.sv
// Self-checking bench for ex_mem: directed scenarios plus randomized traffic
// compared against a behavioural model of the stage.
module tb_ex_mem;

    logic clk;
    logic reset;
    ex_mem_if bus ();

    ex_mem dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model of what the MEM stage currently holds
    logic        mdl_rw, mdl_mtr, mdl_mr, mdl_mw;
    logic [63:0] mdl_alu, mdl_wd;
    logic [4:0]  mdl_dst;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_value(input logic [4:0] r, input logic [63:0] raw);
        if (r == 5'd31) return raw;
        if (mdl_rw && !mdl_mtr && mdl_dst == r) return mdl_alu;
        if (bus.RegWrite_W && bus.DestinationReg_W == r) return bus.Result_W;
        return raw;
    endfunction

    function automatic logic [63:0] ref_alu(input logic [1:0] aop, input logic [10:0] opc,
                                            input logic [63:0] a, input logic [63:0] b);
        if (aop == 2'b01) return b;
        if (aop == 2'b10) begin
            if (opc == 11'b11001011000) return a - b;
            if (opc == 11'b10001010000) return a & b;
            if (opc == 11'b10101010000) return a | b;
        end
        return a + b;
    endfunction

    task automatic clear_inputs();
        bus.EX_MEM_Flush = 1'b0;
        bus.ALUSrc_E = 1'b0; bus.MemToReg_E = 1'b0; bus.RegWrite_E = 1'b0;
        bus.MemRead_E = 1'b0; bus.MemWrite_E = 1'b0; bus.Branch_E = 1'b0;
        bus.ALUOp_E = 2'b00;
        bus.ReadData1_E = 64'd0; bus.ReadData2_E = 64'd0; bus.signExtendedData_E = 64'd0;
        bus.opcode_E = 11'd0;
        bus.DestinationReg_E = 5'd0; bus.Rs1_E = 5'd0; bus.Rs2_E = 5'd0;
        bus.current_pc_E = 10'd0;
        bus.Result_W = 64'd0; bus.RegWrite_W = 1'b0; bus.DestinationReg_W = 5'd0;
    endtask

    // One cycle: check combinational branch outputs, clock, then check MEM outputs
    task automatic step();
        logic [63:0] a, fb, b, res;
        logic [4:0]  rb;
        logic [9:0]  tgt;
        logic        n_rw, n_mtr, n_mr, n_mw;
        logic [63:0] n_alu, n_wd;
        logic [4:0]  n_dst;
        #2;
        rb  = (bus.MemWrite_E || bus.Branch_E) ? bus.DestinationReg_E : bus.Rs2_E;
        a   = ref_value(bus.Rs1_E, bus.ReadData1_E);
        fb  = ref_value(rb, bus.ReadData2_E);
        b   = bus.ALUSrc_E ? bus.signExtendedData_E : fb;
        res = ref_alu(bus.ALUOp_E, bus.opcode_E, a, b);
        tgt = bus.current_pc_E + 10'(bus.signExtendedData_E * 64'd4);
        check_eq("PCSrc_E", 64'(bus.PCSrc_E), 64'(bus.Branch_E && (res == 64'd0)));
        check_eq("BranchTarget_E", 64'(bus.BranchTarget_E), 64'(tgt));
        if (reset) begin
            {n_rw, n_mtr, n_mr, n_mw} = 4'b0000;
            n_alu = 64'd0; n_wd = 64'd0; n_dst = 5'd0;
        end else if (bus.EX_MEM_Flush) begin
            {n_rw, n_mtr, n_mr, n_mw} = 4'b0000;
            n_alu = mdl_alu; n_wd = mdl_wd; n_dst = mdl_dst;
        end else begin
            n_rw = bus.RegWrite_E; n_mtr = bus.MemToReg_E;
            n_mr = bus.MemRead_E;  n_mw = bus.MemWrite_E;
            n_alu = res; n_wd = fb; n_dst = bus.DestinationReg_E;
        end
        @(posedge clk);
        #1;
        mdl_rw = n_rw; mdl_mtr = n_mtr; mdl_mr = n_mr; mdl_mw = n_mw;
        mdl_alu = n_alu; mdl_wd = n_wd; mdl_dst = n_dst;
        check_eq("RegWrite_M", 64'(bus.RegWrite_M), 64'(mdl_rw));
        check_eq("MemToReg_M", 64'(bus.MemToReg_M), 64'(mdl_mtr));
        check_eq("MemRead_M", 64'(bus.MemRead_M), 64'(mdl_mr));
        check_eq("MemWrite_M", 64'(bus.MemWrite_M), 64'(mdl_mw));
        check_eq("ALUResult_M", bus.ALUResult_M, mdl_alu);
        check_eq("WriteData_M", bus.WriteData_M, mdl_wd);
        check_eq("DestinationReg_M", 64'(bus.DestinationReg_M), 64'(mdl_dst));
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 4))
            0: return 5'd1;
            1: return 5'd2;
            2: return 5'd3;
            3: return 5'd31;
            default: return 5'($urandom);
        endcase
    endfunction

    function automatic logic [63:0] pick_val();
        if ($urandom_range(0, 3) == 0) return 64'd0;
        return {$urandom, $urandom};
    endfunction

    function automatic logic [10:0] pick_opc();
        case ($urandom_range(0, 7))
            0: return 11'b10001011000;
            1: return 11'b11001011000;
            2: return 11'b10001010000;
            3: return 11'b10101010000;
            4: return 11'b11111000010;
            5: return 11'b11111000000;
            6: return 11'b10110100000;
            default: return 11'($urandom);
        endcase
    endfunction

    initial begin
        mdl_rw = 1'b0; mdl_mtr = 1'b0; mdl_mr = 1'b0; mdl_mw = 1'b0;
        mdl_alu = 64'd0; mdl_wd = 64'd0; mdl_dst = 5'd0;
        clear_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        step();
        reset = 1'b0;

        // ADD X4 = X1 + X2 without hazards
        clear_inputs();
        bus.opcode_E = 11'b10001011000; bus.ALUOp_E = 2'b10; bus.RegWrite_E = 1'b1;
        bus.Rs1_E = 5'd1; bus.Rs2_E = 5'd2; bus.DestinationReg_E = 5'd4;
        bus.ReadData1_E = 64'd5; bus.ReadData2_E = 64'd7;
        step();
        check_eq("add_result", bus.ALUResult_M, 64'd12);
        check_eq("add_regwrite", 64'(bus.RegWrite_M), 64'd1);

        // SUB X3 = X1 - X2 with X1 from M (100) and X2 from W (40)
        bus.DestinationReg_E = 5'd1; bus.Rs1_E = 5'd5; bus.Rs2_E = 5'd6;
        bus.ReadData1_E = 64'd60; bus.ReadData2_E = 64'd40;
        step();
        bus.opcode_E = 11'b11001011000;
        bus.Rs1_E = 5'd1; bus.Rs2_E = 5'd2; bus.DestinationReg_E = 5'd3;
        bus.ReadData1_E = 64'd0; bus.ReadData2_E = 64'd0;
        bus.RegWrite_W = 1'b1; bus.DestinationReg_W = 5'd2; bus.Result_W = 64'd40;
        step();
        check_eq("sub_fwd", bus.ALUResult_M, 64'd60);

        // M and W both hold X1: M must win
        clear_inputs();
        bus.opcode_E = 11'b10001011000; bus.ALUOp_E = 2'b10; bus.RegWrite_E = 1'b1;
        bus.DestinationReg_E = 5'd1; bus.Rs1_E = 5'd7; bus.Rs2_E = 5'd8;
        bus.ReadData1_E = 64'd4; bus.ReadData2_E = 64'd5;
        step();
        bus.Rs1_E = 5'd1; bus.Rs2_E = 5'd1; bus.DestinationReg_E = 5'd9;
        bus.ReadData1_E = 64'd0; bus.ReadData2_E = 64'd0;
        bus.RegWrite_W = 1'b1; bus.DestinationReg_W = 5'd1; bus.Result_W = 64'd4;
        step();
        check_eq("m_beats_w", bus.ALUResult_M, 64'd18);

        // Same pattern through register 31: raw read data only
        bus.RegWrite_W = 1'b0;
        bus.DestinationReg_E = 5'd31; bus.Rs1_E = 5'd7; bus.Rs2_E = 5'd8;
        bus.ReadData1_E = 64'd4; bus.ReadData2_E = 64'd5;
        step();
        bus.Rs1_E = 5'd31; bus.Rs2_E = 5'd31; bus.DestinationReg_E = 5'd9;
        bus.ReadData1_E = 64'd11; bus.ReadData2_E = 64'd11;
        bus.RegWrite_W = 1'b1; bus.DestinationReg_W = 5'd31; bus.Result_W = 64'd4;
        step();
        check_eq("xzr_no_fwd", bus.ALUResult_M, 64'd22);

        // CBZ with Rt forwarded from W
        clear_inputs();
        step();
        bus.opcode_E = 11'b10110100000; bus.ALUOp_E = 2'b01; bus.Branch_E = 1'b1;
        bus.DestinationReg_E = 5'd5; bus.ReadData2_E = 64'd77;
        bus.signExtendedData_E = 64'd3; bus.current_pc_E = 10'h040;
        bus.RegWrite_W = 1'b1; bus.DestinationReg_W = 5'd5; bus.Result_W = 64'd0;
        #2;
        check_eq("cbz_taken", 64'(bus.PCSrc_E), 64'd1);
        check_eq("cbz_target", 64'(bus.BranchTarget_E), 64'h04C);
        step();
        bus.Result_W = 64'd1;
        #2;
        check_eq("cbz_not_taken", 64'(bus.PCSrc_E), 64'd0);
        step();

        // STUR squashed by flush, then reset together with flush
        clear_inputs();
        bus.opcode_E = 11'b11111000000; bus.MemWrite_E = 1'b1; bus.ALUSrc_E = 1'b1;
        bus.signExtendedData_E = 64'd16; bus.ReadData1_E = 64'd100;
        bus.DestinationReg_E = 5'd6; bus.ReadData2_E = 64'd55;
        bus.EX_MEM_Flush = 1'b1;
        step();
        check_eq("flush_memwrite", 64'(bus.MemWrite_M), 64'd0);
        bus.RegWrite_E = 1'b1; bus.MemRead_E = 1'b1; bus.MemToReg_E = 1'b1;
        reset = 1'b1;
        step();
        check_eq("rst_flush_ctrl",
                 64'({bus.RegWrite_M, bus.MemToReg_M, bus.MemRead_M, bus.MemWrite_M}), 64'd0);
        check_eq("rst_flush_alu", bus.ALUResult_M, 64'd0);
        check_eq("rst_flush_wd", bus.WriteData_M, 64'd0);
        check_eq("rst_flush_dst", 64'(bus.DestinationReg_M), 64'd0);
        reset = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 31) == 0);
            bus.EX_MEM_Flush = ($urandom_range(0, 7) == 0);
            bus.ALUSrc_E   = 1'($urandom);
            bus.MemToReg_E = ($urandom_range(0, 3) == 0);
            bus.RegWrite_E = ($urandom_range(0, 3) != 0);
            bus.MemRead_E  = 1'($urandom);
            bus.MemWrite_E = ($urandom_range(0, 3) == 0);
            bus.Branch_E   = ($urandom_range(0, 3) == 0);
            bus.ALUOp_E    = 2'($urandom);
            bus.ReadData1_E = pick_val();
            bus.ReadData2_E = pick_val();
            bus.signExtendedData_E = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 300))
                                                                 : pick_val();
            bus.opcode_E = pick_opc();
            bus.DestinationReg_E = pick_reg();
            bus.Rs1_E = pick_reg();
            bus.Rs2_E = pick_reg();
            bus.current_pc_E = 10'($urandom);
            bus.Result_W = pick_val();
            bus.RegWrite_W = 1'($urandom);
            bus.DestinationReg_W = pick_reg();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
